// File: rtl/pdcch_pkg.sv
// Shared definitions for the PDCCH DMRS pseudo-random sequence path:
// controller config word, Gold warm-up length and PN generator state encoding.
package pdcch_pkg;

    localparam int PDCCH_NC = 1600;

    typedef struct packed {
        logic [47:0] freq_bit_map;
        logic [15:0] pn_seq_len;
        logic [15:0] dmrs_offset;
        logic [31:0] c_init;
    } pdcch_controller_configs;

    typedef enum logic [1:0] {
        PN_IDLE   = 2'd0,
        PN_WARMUP = 2'd1,
        PN_GEN    = 2'd2,
        PN_OUT    = 2'd3
    } pn_state_t;

endpackage

// File: rtl/pdcch_gold_lfsr.sv
// x1/x2 Gold-sequence LFSR pair; one step per cycle when step is high.
// chip always reflects the current register state, c(n) = x1(n) ^ x2(n).
module pdcch_gold_lfsr (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [30:0] x2_init,
    input  logic        step,
    output logic        chip
);

    logic [30:0] x1_q;
    logic [30:0] x1_d;
    logic [30:0] x2_q;
    logic [30:0] x2_d;

    // Bit 0 holds x(n); the new bit x(n+31) enters at bit 30.
    always_comb begin
        x1_d = x1_q;
        x2_d = x2_q;
        if (load) begin
            x1_d = 31'h1;
            x2_d = x2_init;
        end else if (step) begin
            x1_d = {x1_q[3] ^ x1_q[0], x1_q[30:1]};
            x2_d = {x2_q[3] ^ x2_q[2] ^ x2_q[1] ^ x2_q[0], x2_q[30:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x1_q <= '0;
            x2_q <= '0;
        end else begin
            x1_q <= x1_d;
            x2_q <= x2_d;
        end
    end

    assign chip = x1_q[0] ^ x2_q[0];

endmodule

// File: rtl/pdcch_pn_seq_gen.sv
// Gold PN generator for PDCCH DMRS: seeds from C_init, discards NC+dmrs_offset
// chips, then streams pn_seq_len chips packed LSB-first into OUT_W-bit beats.
module pdcch_pn_seq_gen
    import pdcch_pkg::*;
#(
    parameter int CFG_W = $bits(pdcch_controller_configs),
    parameter int OUT_W = 32,
    parameter int NC    = PDCCH_NC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CFG_W-1:0] s_axis_pn_config_data,
    input  logic             s_axis_pn_config_valid,
    output logic             s_axis_pn_config_ready,
    output logic [OUT_W-1:0] m_axis_pn_data,
    output logic             m_axis_pn_valid,
    output logic             m_axis_pn_last,
    input  logic             m_axis_pn_ready,
    output logic             busy
);

    localparam int IDX_W  = $clog2(OUT_W + 1);
    localparam int WARM_W = 17;

    pdcch_controller_configs cfg_in;
    logic                    cfg_unused;

    pn_state_t          state_q, state_d;
    logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
    logic [15:0]        chip_cnt_q, chip_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [OUT_W-1:0]   word_q, word_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;

    logic               lfsr_load;
    logic               lfsr_step;
    logic               chip;
    logic [OUT_W-1:0]   bit_sel;

    assign cfg_in     = pdcch_controller_configs'(s_axis_pn_config_data);
    assign cfg_unused = ^{cfg_in.freq_bit_map, cfg_in.c_init[31]};

    pdcch_gold_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (lfsr_load),
        .x2_init (cfg_in.c_init[30:0]),
        .step    (lfsr_step),
        .chip    (chip)
    );

    // One-hot decode of the current write position within the beat.
    genvar gi;
    generate
        for (gi = 0; gi < OUT_W; gi++) begin : g_sel
            assign bit_sel[gi] = (idx_q == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        chip_cnt_d = chip_cnt_q;
        idx_d      = idx_q;
        word_d     = word_q;
        valid_d    = valid_q;
        last_d     = last_q;
        busy_d     = busy_q;
        ready_d    = ready_q;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;

        case (state_q)
            PN_IDLE: begin
                ready_d = 1'b1;
                if (s_axis_pn_config_valid && ready_q) begin
                    lfsr_load  = 1'b1;
                    warm_cnt_d = WARM_W'(NC) + WARM_W'(cfg_in.dmrs_offset);
                    chip_cnt_d = cfg_in.pn_seq_len;
                    idx_d      = '0;
                    word_d     = '0;
                    last_d     = 1'b0;
                    // A zero-length request is consumed without leaving IDLE.
                    if (cfg_in.pn_seq_len != 16'd0) begin
                        state_d = PN_WARMUP;
                        busy_d  = 1'b1;
                        ready_d = 1'b0;
                    end
                end
            end

            PN_WARMUP: begin
                if (warm_cnt_q == '0) begin
                    state_d = PN_GEN;
                end else begin
                    lfsr_step  = 1'b1;
                    warm_cnt_d = warm_cnt_q - WARM_W'(1);
                end
            end

            PN_GEN: begin
                lfsr_step  = 1'b1;
                word_d     = word_q | (bit_sel & {OUT_W{chip}});
                idx_d      = idx_q + IDX_W'(1);
                chip_cnt_d = chip_cnt_q - 16'd1;
                if (idx_d == IDX_W'(OUT_W) || chip_cnt_d == 16'd0) begin
                    state_d = PN_OUT;
                    valid_d = 1'b1;
                    last_d  = (chip_cnt_d == 16'd0);
                end
            end

            PN_OUT: begin
                if (m_axis_pn_ready) begin
                    valid_d = 1'b0;
                    idx_d   = '0;
                    word_d  = '0;
                    if (last_q) begin
                        state_d = PN_IDLE;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        last_d  = 1'b0;
                    end else begin
                        state_d = PN_GEN;
                    end
                end
            end

            default: state_d = PN_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= PN_IDLE;
            warm_cnt_q <= '0;
            chip_cnt_q <= '0;
            idx_q      <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            chip_cnt_q <= chip_cnt_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    assign s_axis_pn_config_ready = ready_q;
    assign m_axis_pn_data         = word_q;
    assign m_axis_pn_valid        = valid_q;
    assign m_axis_pn_last         = last_q;
    assign busy                   = busy_q;

endmodule

// File: tb/tb_pdcch_pn_seq_gen.sv
// Bench for pdcch_pn_seq_gen: Gold-sequence model built from the x1/x2
// recurrences, a per-cycle output checker and directed scenario runs.
module tb_pdcch_pn_seq_gen;
    import pdcch_pkg::*;

    localparam int OUT_W = 32;
    localparam int NC    = 1600;
    localparam int CFG_W = $bits(pdcch_controller_configs);

    logic             clk = 1'b0;
    logic             reset;
    logic [CFG_W-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic [OUT_W-1:0] m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;
    logic             busy;

    always #5 clk = ~clk;

    pdcch_pn_seq_gen #(.OUT_W(OUT_W), .NC(NC)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_pn_config_data  (s_data),
        .s_axis_pn_config_valid (s_valid),
        .s_axis_pn_config_ready (s_ready),
        .m_axis_pn_data         (m_data),
        .m_axis_pn_valid        (m_valid),
        .m_axis_pn_last         (m_last),
        .m_axis_pn_ready        (m_ready),
        .busy                   (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [OUT_W-1:0] exp_data_q[$];
    bit               exp_last_q[$];
    bit               g_x1[];
    bit               g_x2[];

    int               rise_cnt = 0;
    int               rise_cyc = 0;
    int               beat_cnt = 0;
    logic [OUT_W-1:0] last_beat_data = '0;
    int               rmode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Direct recurrences: x1(n+31)=x1(n+3)+x1(n), x2(n+31)=x2(n+3)+x2(n+2)+x2(n+1)+x2(n).
    task automatic fill_gold(input logic [30:0] ci, input int n);
        g_x1 = new[n + 31];
        g_x2 = new[n + 31];
        for (int i = 0; i < 31; i++) begin
            g_x1[i] = (i == 0);
            g_x2[i] = ci[i];
        end
        for (int k = 0; k < n; k++) begin
            g_x1[k + 31] = g_x1[k + 3] ^ g_x1[k];
            g_x2[k + 31] = g_x2[k + 3] ^ g_x2[k + 2] ^ g_x2[k + 1] ^ g_x2[k];
        end
    endtask

    task automatic model_push(input logic [30:0] ci, input int off, input int len);
        int               base;
        logic [OUT_W-1:0] w;
        base = NC + off;
        if (len == 0) return;
        fill_gold(ci, base + len);
        w = '0;
        for (int k = 0; k < len; k++) begin
            w[k % OUT_W] = g_x1[base + k] ^ g_x2[base + k];
            if ((k % OUT_W) == OUT_W - 1 || k == len - 1) begin
                exp_data_q.push_back(w);
                exp_last_q.push_back(k == len - 1);
                w = '0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output checker: every cycle valid is high must match the head of the model queue.
    initial begin
        bit prev_valid;
        bit prev_ready;
        prev_valid = 0;
        prev_ready = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_valid = 0;
                prev_ready = 0;
            end else begin
                if (prev_valid && !prev_ready && !m_valid) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL valid_drop: valid fell without handshake (cycle %0d)", cyc);
                end
                if (m_valid) begin
                    if (!prev_valid) begin
                        rise_cnt++;
                        rise_cyc = cyc;
                    end
                    if (exp_data_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_beat: data 0x%0h with no beat required (cycle %0d)", m_data, cyc);
                    end else begin
                        check("beat_data", m_data, exp_data_q[0]);
                        check("beat_last", m_last, exp_last_q[0]);
                        if (m_ready) begin
                            beat_cnt++;
                            last_beat_data = m_data;
                            void'(exp_data_q.pop_front());
                            void'(exp_last_q.pop_front());
                        end
                    end
                end
                prev_valid = m_valid;
                prev_ready = m_ready;
            end
        end
    end

    // Downstream ready: 0 = always ready, 1 = seven stalled cycles per beat, 2 = never ready.
    initial begin
        int hold;
        hold = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: m_ready = 1'b1;
                1: begin
                    if (m_valid && hold < 7) begin
                        m_ready = 1'b0;
                        hold++;
                    end else if (m_valid) begin
                        m_ready = 1'b1;
                        hold = 0;
                    end else begin
                        m_ready = 1'b0;
                        hold = 0;
                    end
                end
                default: m_ready = 1'b0;
            endcase
        end
    end

    task automatic send_cfg(input logic [31:0] ci, input int off, input int len, output int acc);
        pdcch_controller_configs c;
        c              = '0;
        c.c_init       = ci;
        c.dmrs_offset  = 16'(off);
        c.pn_seq_len   = 16'(len);
        c.freq_bit_map = 48'hA5A5_0F0F_FFFF;
        s_data  = c;
        s_valid = 1'b1;
        acc     = -1;
        for (int i = 0; i < 50 && acc < 0; i++) begin
            @(negedge clk);
            if (s_ready) acc = cyc + 1;
        end
        if (acc < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL cfg_accept: ready never seen, required 1");
        end else begin
            model_push(ci[30:0], off, len);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(input int r0, input int budget, output int cv);
        cv = -1;
        for (int i = 0; i < budget && cv < 0; i++) begin
            @(posedge clk);
            #1;
            if (rise_cnt > r0) cv = rise_cyc;
        end
        if (cv < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL valid_timeout: no valid within %0d cycles", budget);
        end
    endtask

    task automatic wait_done(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #1;
            if (exp_data_q.size() == 0 && !busy) done = 1;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: %0d beats outstanding, busy %0b", exp_data_q.size(), busy);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  m_data,  '0);
        check({tag, "_valid"}, m_valid, 0);
        check({tag, "_last"},  m_last,  0);
        check({tag, "_busy"},  busy,    0);
        check({tag, "_ready"}, s_ready, 0);
    endtask

    task automatic flush_model();
        exp_data_q.delete();
        exp_last_q.delete();
    endtask

    initial begin
        int acc, acc2, rc, r0, b0, lat0, lat5;
        reset   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", s_ready, 1);

        // Hand-derived early sequence values pin the model itself.
        fill_gold(31'h1, 40);
        check("pin_x1_31", g_x1[31], 1);
        check("pin_x1_32", g_x1[32], 0);
        check("pin_x1_59", g_x1[59], 1);
        check("pin_x1_62", g_x1[62], 1);
        check("pin_x2_31", g_x2[31], 1);
        check("pin_x2_32", g_x2[32], 0);

        // Single full beat from x1 alone.
        r0 = rise_cnt; b0 = beat_cnt;
        send_cfg(32'h0, 0, 32, acc);
        s_valid = 1'b0;
        check("busy_running", busy, 1);
        check("ready_running", s_ready, 0);
        wait_rise(r0, 2000, rc);
        check("lat_len32", 64'(rc - acc), 64'd1633);
        wait_done(200);
        check("beats_len32", 64'(beat_cnt - b0), 64'd1);
        $display("run c_init=0 len=32: latency %0d, beats %0d", rc - acc, beat_cnt - b0);

        // Partial final word; C_init bit 31 must be ignored.
        r0 = rise_cnt; b0 = beat_cnt;
        send_cfg(32'h8001_2345, 0, 70, acc);
        s_valid = 1'b0;
        wait_rise(r0, 2000, rc);
        check("lat_len70", 64'(rc - acc), 64'd1633);
        wait_done(300);
        check("beats_len70", 64'(beat_cnt - b0), 64'd3);
        check("beat3_upper", 64'(last_beat_data[31:6]), 64'd0);
        $display("run c_init=12345 len=70: beats %0d", beat_cnt - b0);

        // dmrs_offset shifts the stream and the latency.
        r0 = rise_cnt;
        send_cfg(32'h0001_2345, 0, 32, acc);
        s_valid = 1'b0;
        wait_rise(r0, 2000, rc);
        lat0 = rc - acc;
        wait_done(200);
        r0 = rise_cnt;
        send_cfg(32'h0001_2345, 5, 32, acc);
        s_valid = 1'b0;
        wait_rise(r0, 2000, rc);
        lat5 = rc - acc;
        wait_done(200);
        check("lat_off0", 64'(lat0), 64'd1633);
        check("lat_off5_delta", 64'(lat5 - lat0), 64'd5);
        $display("run offset: latency %0d vs %0d", lat5, lat0);

        // Backpressure: same stream, seven stalls per beat.
        rmode = 1;
        r0 = rise_cnt; b0 = beat_cnt;
        send_cfg(32'h0001_2345, 0, 70, acc);
        s_valid = 1'b0;
        wait_rise(r0, 2000, rc);
        wait_done(400);
        check("beats_bp", 64'(beat_cnt - b0), 64'd3);
        rmode = 0;
        $display("run backpressure len=70: beats %0d", beat_cnt - b0);

        // Zero length followed immediately by a real request.
        b0 = beat_cnt;
        send_cfg(32'h0001_2345, 0, 0, acc);
        check("busy_len0", busy, 0);
        check("ready_len0", s_ready, 1);
        send_cfg(32'h0000_0777, 2, 32, acc2);
        s_valid = 1'b0;
        check("accept_after_len0", 64'(acc2 - acc), 64'd1);
        wait_done(2000);
        check("beats_after_len0", 64'(beat_cnt - b0), 64'd1);
        $display("run zero length: second accept %0d cycles later", acc2 - acc);

        // Reset during WARMUP.
        send_cfg(32'h0001_2345, 0, 32, acc);
        s_valid = 1'b0;
        repeat (100) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("rst_warm_busy", busy, 0);
        check("rst_warm_valid", m_valid, 0);
        flush_model();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_warm_ready", s_ready, 1);

        // Reset while a beat is stalled in OUT.
        rmode = 2;
        r0 = rise_cnt;
        send_cfg(32'h0001_2345, 0, 32, acc);
        s_valid = 1'b0;
        wait_rise(r0, 2000, rc);
        repeat (3) @(posedge clk);
        #3;
        check("stall_valid_held", m_valid, 1);
        reset = 1'b0;
        #1;
        check_all_zero("rst_out");
        flush_model();
        rmode = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_ready", s_ready, 1);

        r0 = rise_cnt; b0 = beat_cnt;
        send_cfg(32'h0001_2345, 3, 70, acc);
        s_valid = 1'b0;
        wait_rise(r0, 2000, rc);
        check("lat_after_reset", 64'(rc - acc), 64'd1636);
        wait_done(300);
        check("beats_after_reset", 64'(beat_cnt - b0), 64'd3);
        $display("run after reset len=70 off=3: latency %0d, beats %0d", rc - acc, beat_cnt - b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
